seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_hit_counter.sv | 25 ++
 rtl/seq_pattern_detector.sv | 74 +++++++
 tb/tb_seq_pattern_detector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and the fill-width helper for the pattern detector
package seq_det_pkg;

  localparam int       DEF_N       = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1010;
  localparam int       DEF_CNT_W   = 8;

  // Width needed to hold a fill level from 0 up to and including n.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// rtl/seq_hit_counter.sv - saturating match counter with synchronous clear
module seq_hit_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear wins over counting, but a hit in the clearing cycle is still counted as the first one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (clr) begin
      count <= {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial bit-pattern detector with runtime pattern and hit counter
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int           N       = DEF_N,
  parameter logic [N-1:0] PATTERN = N'(DEF_PATTERN),
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 en,
  input  logic                 x,
  input  logic                 pat_load,
  input  logic [N-1:0]         pat_in,
  input  logic                 cnt_clr,
  output logic                 y,
  output logic [CNT_W-1:0]     hit_count,
  output logic [fill_w(N)-1:0] fill
);

  localparam int            FW        = fill_w(N);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  pat_r;
  logic [N-1:0]  hist;
  logic [N-1:0]  hist_nx;
  logic [FW-1:0] fill_nx;
  logic          sample;
  logic          match;
  // The oldest history bit shifts out without feeding back into anything.
  logic          hist_msb_unused;

  assign hist_msb_unused = hist[N-1];

  // Post-shift history/fill and the match decision; a load cycle never samples.
  always_comb begin
    sample  = en & ~pat_load;
    hist_nx = {hist[N-2:0], x};
    fill_nx = (fill == FILL_FULL) ? fill : fill + FW'(1);
    match   = sample && (hist_nx == pat_r) && (fill_nx == FILL_FULL);
  end

  // Pattern, history, fill and the registered match pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pat_r <= PATTERN;
      hist  <= '0;
      fill  <= '0;
      y     <= 1'b0;
    end else begin
      y <= match;
      if (pat_load) begin
        pat_r <= pat_in;
        hist  <= '0;
        fill  <= '0;
      end else if (en) begin
        hist <= hist_nx;
        fill <= (match && !OVERLAP) ? '0 : fill_nx;
      end
    end
  end

  seq_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (match),
    .clr   (cnt_clr),
    .count (hit_count)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - randomized and directed bench for seq_pattern_detector
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en;
  logic       x;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       y_a, y_b, y_c;
  logic [2:0] fill_a, fill_b, fill_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // a: defaults (overlap); b: no overlap; c: no overlap with a 2-bit counter
  seq_pattern_detector #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .clr_n(clr_n), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .y(y_a), .hit_count(cnt_a), .fill(fill_a));
  seq_pattern_detector #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .clr_n(clr_n), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .y(y_b), .hit_count(cnt_b), .fill(fill_b));
  seq_pattern_detector #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .clr_n(clr_n), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .y(y_c), .hit_count(cnt_c), .fill(fill_c));

  logic       ys[3];
  logic [2:0] fs[3];
  logic [7:0] cs[3];
  assign ys[0] = y_a;
  assign ys[1] = y_b;
  assign ys[2] = y_c;
  assign fs[0] = fill_a;
  assign fs[1] = fill_b;
  assign fs[2] = fill_c;
  assign cs[0] = cnt_a;
  assign cs[1] = cnt_b;
  assign cs[2] = {6'b0, cnt_c};

  // Reference model: bits received since the last restart, oldest first, trimmed to the last 4.
  bit mq[3][$];
  int mpat[3];
  int mcnt[3];
  bit my[3];
  int ov[3]   = '{1, 0, 0};
  int cmax[3] = '{255, 255, 3};

  function automatic int qval(input int k);
    int v = 0;
    for (int i = 0; i < mq[k].size(); i++) v = (v << 1) | int'(mq[k][i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mpat[k] = 10;
      mcnt[k] = 0;
      my[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic e, input logic xb, input logic pl,
                            input logic [3:0] pi, input logic cc);
    bit hit;
    for (int k = 0; k < 3; k++) begin
      hit = 1'b0;
      if (pl) begin
        mpat[k] = int'(pi);
        mq[k].delete();
      end else if (e) begin
        mq[k].push_back(xb);
        if (mq[k].size() > 4) void'(mq[k].pop_front());
        hit = (mq[k].size() == 4) && (qval(k) == mpat[k]);
        if (hit && ov[k] == 0) mq[k].delete();
      end
      my[k] = hit;
      if (cc) mcnt[k] = hit ? 1 : 0;
      else if (hit && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle at the falling edge.
  task automatic tick(input logic e, input logic xb, input logic pl,
                      input logic [3:0] pi, input logic cc);
    en = e; x = xb; pat_load = pl; pat_in = pi; cnt_clr = cc;
    @(posedge clk);
    model_step(e, xb, pl, pi, cc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; x = 1'b0; pat_load = 1'b0; pat_in = 4'h0; cnt_clr = 1'b0;
    @(negedge clk);
    clr_n = 1'b0;
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    bit b3[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, b3[i], 1'b0, 4'h0, 1'b0);
    compared++;
    if (fill_a !== 3'd3) begin mismatched++; $display("FAIL rst_prefill got %0d want 3", fill_a); end
    clr_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (fill_a !== 3'd0 || y_a !== 1'b0 || cnt_a !== 8'd0) begin
      mismatched++;
      $display("FAIL rst_async fill=%0d y=%b cnt=%0d want 0/0/0", fill_a, y_a, cnt_a);
    end
    @(negedge clk);
    clr_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    compared++;
    if (y_a !== 1'b0 || fill_a !== 3'd1 || cnt_a !== 8'd0) begin
      mismatched++;
      $display("FAIL rst_after y=%b fill=%0d cnt=%0d want 0/1/0", y_a, fill_a, cnt_a);
    end
  endtask

  task automatic test_single();
    bit b4[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, b4[i], 1'b0, 4'h0, 1'b0);
      compared++;
      if (y_a !== (i == 3)) begin mismatched++; $display("FAIL single_y bit %0d got %b want %b", i + 1, y_a, i == 3); end
    end
    compared++;
    if (cnt_a !== 8'd1 || fill_a !== 3'd4) begin
      mismatched++;
      $display("FAIL single_cnt_fill cnt=%0d fill=%0d want 1/4", cnt_a, fill_a);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    compared++;
    if (y_a !== 1'b0) begin mismatched++; $display("FAIL single_pulse_width got %b want 0", y_a); end
  endtask

  task automatic test_overlap();
    bit b6[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, b6[i], 1'b0, 4'h0, 1'b0);
      compared++;
      if (y_a !== (i == 3 || i == 5)) begin mismatched++; $display("FAIL ovl_y_a bit %0d got %b want %b", i + 1, y_a, i == 3 || i == 5); end
      compared++;
      if (y_b !== (i == 3)) begin mismatched++; $display("FAIL novl_y_b bit %0d got %b want %b", i + 1, y_b, i == 3); end
    end
    compared++;
    if (cnt_a !== 8'd2 || cnt_b !== 8'd1) begin
      mismatched++;
      $display("FAIL ovl_counts a=%0d b=%0d want 2/1", cnt_a, cnt_b);
    end
  endtask

  task automatic test_gate();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    compared++;
    if (y_a !== 1'b0 || fill_a !== 3'd2) begin
      mismatched++;
      $display("FAIL gate_hold y=%b fill=%0d want 0/2", y_a, fill_a);
    end
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    compared++;
    if (y_a !== 1'b0) begin mismatched++; $display("FAIL gate_early got %b want 0", y_a); end
    tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    compared++;
    if (y_a !== 1'b1 || cnt_a !== 8'd1) begin
      mismatched++;
      $display("FAIL gate_hit y=%b cnt=%0d want 1/1", y_a, cnt_a);
    end
  endtask

  task automatic test_load();
    bit b8[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    tick(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    compared++;
    if (fill_a !== 3'd0 || y_a !== 1'b0) begin
      mismatched++;
      $display("FAIL load_clear fill=%0d y=%b want 0/0", fill_a, y_a);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, b8[i], 1'b0, 4'h0, 1'b0);
      compared++;
      if (y_a !== (i == 7)) begin mismatched++; $display("FAIL load_y bit %0d got %b want %b", i + 1, y_a, i == 7); end
    end
    compared++;
    if (cnt_a !== 8'd1) begin mismatched++; $display("FAIL load_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    end
    compared++;
    if (cnt_c !== 2'd3 || cnt_b !== 8'd5) begin
      mismatched++;
      $display("FAIL sat_count c=%0d b=%0d want 3/5", cnt_c, cnt_b);
    end
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    compared++;
    if (cnt_c !== 2'd1 || y_c !== 1'b1 || cnt_b !== 8'd1) begin
      mismatched++;
      $display("FAIL clr_with_hit c=%0d y=%b b=%0d want 1/1/1", cnt_c, y_c, cnt_b);
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    compared++;
    if (cnt_c !== 2'd0 || fill_a === 3'd0) begin
      mismatched++;
      $display("FAIL clr_no_hit cnt=%0d fill_a=%0d want 0/nonzero", cnt_c, fill_a);
    end
  endtask

  task automatic test_random();
    logic e, xb, pl, cc;
    logic [3:0] pi;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      e  = ($urandom_range(7) != 0);
      xb = $urandom_range(1);
      pl = ($urandom_range(63) == 0);
      pi = 4'($urandom_range(15));
      cc = ($urandom_range(49) == 0);
      tick(e, xb, pl, pi, cc);
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (ys[k] !== my[k] || fs[k] !== 3'(mq[k].size()) || cs[k] !== 8'(mcnt[k])) begin
          mismatched++;
          $display("FAIL rand dut%0d cyc %0d y=%b fill=%0d cnt=%0d want %b/%0d/%0d",
                   k, n, ys[k], fs[k], cs[k], my[k], mq[k].size(), mcnt[k]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; en = 1'b0; x = 1'b0; pat_load = 1'b0; pat_in = 4'h0; cnt_clr = 1'b0;
    model_reset();
    #1;
    compared++;
    if (y_a !== 1'b0 || fill_a !== 3'd0 || cnt_a !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_state y=%b fill=%0d cnt=%0d want 0/0/0", y_a, fill_a, cnt_a);
    end
    test_reset();
    test_single();
    test_overlap();
    test_gate();
    test_load();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
